// File: rtl/stack_cmd_driver.sv
// Sequencer for a 5-entry circular stack: push/pop/get requests in, stack commands out, responses back.
// Latency from request acceptance to RSP_VALID: push 2, pop/get 3, rejected request 1 cycle.
// Backpressure: REQ_READY only in IDLE (one request in flight); RSP_VALID/DATA/ERR held until RSP_READY.
//
// Ports:
//   CLK, RESET        clock and synchronous active-high reset (shared with the stack)
//   REQ_*             request channel: op (01 push, 10 pop, 11 get), push data, get offset
//   RSP_*             response channel: read data (0 for push/errors) and reject flag
//   DEPTH             tracked occupancy, 0..DEPTH_MAX
//   STK_COMMAND/INDEX stack command lines, all registered
//   STK_DATA          shared tri-state bus, driven by this block only in a push ISSUE cycle
module stack_cmd_driver #(
  parameter int DEPTH_MAX    = 5,
  parameter int DATA_W       = 4,
  parameter int INDEX_W      = 3,
  parameter bit CHECK_BOUNDS = 1'b1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic [1:0]         REQ_OP,
  input  logic [DATA_W-1:0]  REQ_DATA,
  input  logic [INDEX_W-1:0] REQ_INDEX,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [DATA_W-1:0]  RSP_DATA,
  output logic               RSP_ERR,
  output logic [2:0]         DEPTH,
  output logic [1:0]         STK_COMMAND,
  output logic [INDEX_W-1:0] STK_INDEX,
  inout  wire  [DATA_W-1:0]  STK_DATA
);

  typedef enum logic [1:0] {IDLE, ISSUE, SAMPLE, RESP} state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_GET  = 2'b11;
  localparam logic [2:0] DEPTH_FULL = 3'(DEPTH_MAX);

  state_t              state_q, state_nxt;
  logic [1:0]          op_q, op_nxt;
  logic                drv_en_q, drv_en_nxt;
  logic [DATA_W-1:0]   drv_dat_q, drv_dat_nxt;
  logic                req_ready_nxt;
  logic                rsp_valid_nxt;
  logic [DATA_W-1:0]   rsp_data_nxt;
  logic                rsp_err_nxt;
  logic [2:0]          depth_nxt;
  logic [1:0]          cmd_nxt;
  logic [INDEX_W-1:0]  idx_nxt;

  logic op_nop, bounds_err, req_err;

  // Rejection is decided against the live DEPTH at the acceptance edge; nothing
  // else can change DEPTH while IDLE, so this matches the state the op would see.
  assign op_nop     = (REQ_OP == OP_NOP);
  assign bounds_err = ((REQ_OP == OP_PUSH) && (DEPTH == DEPTH_FULL)) ||
                      ((REQ_OP == OP_POP)  && (DEPTH == 3'd0)) ||
                      ((REQ_OP == OP_GET)  && (32'(REQ_INDEX) >= 32'(DEPTH)));
  assign req_err    = CHECK_BOUNDS ? (bounds_err || op_nop) : 1'b0;

  // Bus is released in every state but a push ISSUE; the stack drives it in SAMPLE.
  assign STK_DATA = drv_en_q ? drv_dat_q : {DATA_W{1'bz}};

  always_comb begin
    state_nxt     = state_q;
    op_nxt        = op_q;
    drv_en_nxt    = 1'b0;
    drv_dat_nxt   = drv_dat_q;
    rsp_valid_nxt = RSP_VALID;
    rsp_data_nxt  = RSP_DATA;
    rsp_err_nxt   = RSP_ERR;
    depth_nxt     = DEPTH;
    cmd_nxt       = OP_NOP;
    idx_nxt       = '0;

    unique case (state_q)
      IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          op_nxt       = REQ_OP;
          drv_dat_nxt  = REQ_DATA;
          rsp_data_nxt = '0;
          rsp_err_nxt  = req_err;
          if (req_err || op_nop) begin
            // Rejected requests, and nops when bounds checking is off,
            // respond directly without touching the stack.
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
          end else begin
            state_nxt  = ISSUE;
            cmd_nxt    = REQ_OP;
            idx_nxt    = REQ_INDEX;
            drv_en_nxt = (REQ_OP == OP_PUSH);
          end
        end
      end
      ISSUE: begin
        if (op_q == OP_PUSH) begin
          depth_nxt     = (DEPTH == DEPTH_FULL) ? DEPTH : DEPTH + 3'd1;
          state_nxt     = RESP;
          rsp_valid_nxt = 1'b1;
        end else begin
          if (op_q == OP_POP) begin
            depth_nxt = (DEPTH == 3'd0) ? DEPTH : DEPTH - 3'd1;
          end
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        // Stack is driving read data this cycle; the nop on STK_COMMAND
        // releases its driver at the same edge that captures it here.
        rsp_data_nxt  = STK_DATA;
        rsp_valid_nxt = 1'b1;
        state_nxt     = RESP;
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    req_ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      op_q        <= OP_NOP;
      drv_en_q    <= 1'b0;
      drv_dat_q   <= '0;
      REQ_READY   <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_DATA    <= '0;
      RSP_ERR     <= 1'b0;
      DEPTH       <= 3'd0;
      STK_COMMAND <= OP_NOP;
      STK_INDEX   <= '0;
    end else begin
      state_q     <= state_nxt;
      op_q        <= op_nxt;
      drv_en_q    <= drv_en_nxt;
      drv_dat_q   <= drv_dat_nxt;
      REQ_READY   <= req_ready_nxt;
      RSP_VALID   <= rsp_valid_nxt;
      RSP_DATA    <= rsp_data_nxt;
      RSP_ERR     <= rsp_err_nxt;
      DEPTH       <= depth_nxt;
      STK_COMMAND <= cmd_nxt;
      STK_INDEX   <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_stack_cmd_driver.sv
// Bench for stack_cmd_driver: behavioural 5-entry circular stack on the shared bus,
// table of requests with expected responses, scoreboard queue checked on each handshake,
// plus hand sequences for response backpressure and reset during SAMPLE.
module tb_stack_cmd_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [3:0] req_data;
  logic [2:0] req_index;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [3:0] rsp_data;
  logic [2:0] depth;
  logic [1:0] stk_command;
  logic [2:0] stk_index;
  tri0  [3:0] stk_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stack_cmd_driver dut (
    .CLK(clk), .RESET(reset),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_OP(req_op),
    .REQ_DATA(req_data), .REQ_INDEX(req_index),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
    .DEPTH(depth), .STK_COMMAND(stk_command), .STK_INDEX(stk_index), .STK_DATA(stk_data)
  );

  // Circular stack: captures on the posedge where COMMAND is seen, drives read
  // data during the following cycle, releases on the next edge.
  logic [3:0] mem [0:4];
  int         sp;
  logic       sm_en;
  logic [3:0] sm_dat;

  assign stk_data = sm_en ? sm_dat : 4'bzzzz;

  always @(posedge clk) begin
    if (reset) begin
      sp    <= 0;
      sm_en <= 1'b0;
    end else begin
      sm_en <= 1'b0;
      case (stk_command)
        2'b01: begin
          mem[(sp + 1) % 5] <= stk_data;
          sp <= (sp + 1) % 5;
        end
        2'b10: begin
          sm_dat <= mem[sp];
          sm_en  <= 1'b1;
          sp     <= (sp + 4) % 5;
        end
        2'b11: begin
          sm_dat <= mem[(sp + 10 - int'(stk_index)) % 5];
          sm_en  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %0h, expected %0h", name, id, act, exp);
    end
  endtask

  // Scoreboard
  typedef struct packed {
    logic [3:0] data;
    logic       err;
  } rsp_t;
  rsp_t exp_q[$];

  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      check("rsp_expected", 0, exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_data", 0, 32'(rsp_data), 32'(e.data));
        check("rsp_err", 0, 32'(rsp_err), 32'(e.err));
      end
    end
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] idx;
    logic       err;
    logic [3:0] rdata;
    logic [2:0] dep;
    int         lat;
  } vec_t;

  function automatic vec_t mk(input int op, input int d, input int idx, input int e,
                              input int rd, input int dep, input int lat);
    vec_t v;
    v.op    = 2'(op);
    v.data  = 4'(d);
    v.idx   = 3'(idx);
    v.err   = 1'(e);
    v.rdata = 4'(rd);
    v.dep   = 3'(dep);
    v.lat   = lat;
    return v;
  endfunction

  task automatic do_req(input vec_t v, input int hold, input int id);
    int  t;
    int  lat;
    bit  got;
    rsp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = v.op;
    req_data  = v.data;
    req_index = v.idx;
    rsp_ready = (hold == 0);
    t = 0;
    while (req_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("req_accept", id, 32'(req_ready), 1);
    e.data = v.rdata;
    e.err  = v.err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (v.err || v.op == 2'd0) begin
          check("cmd_quiet", id, 32'(stk_command), 0);
        end else begin
          check("issue_cmd", id, 32'(stk_command), 32'(v.op));
          check("issue_idx", id, 32'(stk_index), 32'(v.idx));
          if (v.op == 2'd1) check("push_bus", id, 32'(stk_data), 32'(v.data));
        end
      end
      if (lat == 2 && !v.err && v.op != 2'd1) begin
        check("sample_cmd", id, 32'(stk_command), 0);
        check("sample_bus", id, 32'(stk_data), 32'(v.rdata));
      end
      if (lat == 2 && !v.err && v.op == 2'd1) begin
        check("bus_released", id, 32'(stk_data), 0);
      end
      got = (rsp_valid === 1'b1);
    end
    check("latency", id, lat, v.lat);
    check("busy_ready", id, 32'(req_ready), 0);

    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        check("hold_valid", id, 32'(rsp_valid), 1);
        check("hold_data", id, 32'(rsp_data), 32'(v.rdata));
        check("hold_ready", id, 32'(req_ready), 0);
        if (h < hold - 1) @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end

    @(negedge clk);
    check("depth", id, 32'(depth), 32'(v.dep));
    check("idle_ready", id, 32'(req_ready), 1);
    check("idle_valid", id, 32'(rsp_valid), 0);
  endtask

  vec_t tbl[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // op, data, idx, err, rdata, depth_after, latency
    tbl.push_back(mk(1, 3, 0, 0, 0, 1, 2));
    tbl.push_back(mk(1, 7, 0, 0, 0, 2, 2));
    tbl.push_back(mk(1, 9, 0, 0, 0, 3, 2));
    tbl.push_back(mk(3, 0, 0, 0, 9, 3, 3));
    tbl.push_back(mk(3, 0, 2, 0, 3, 3, 3));
    tbl.push_back(mk(2, 0, 0, 0, 9, 2, 3));
    tbl.push_back(mk(2, 0, 0, 0, 7, 1, 3));
    tbl.push_back(mk(2, 0, 0, 0, 3, 0, 3));
    tbl.push_back(mk(2, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 2));
    tbl.push_back(mk(1, 2, 0, 0, 0, 2, 2));
    tbl.push_back(mk(1, 4, 0, 0, 0, 3, 2));
    tbl.push_back(mk(1, 6, 0, 0, 0, 4, 2));
    tbl.push_back(mk(1, 8, 0, 0, 0, 5, 2));
    tbl.push_back(mk(1, 11, 0, 1, 0, 5, 1));
    tbl.push_back(mk(3, 0, 5, 1, 0, 5, 1));
    tbl.push_back(mk(3, 0, 4, 0, 1, 5, 3));
    tbl.push_back(mk(3, 0, 3, 0, 2, 5, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0, 5, 1));
    tbl.push_back(mk(3, 0, 7, 1, 0, 5, 1));

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_data  = 4'd0;
    req_index = 3'd0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 0, 32'(req_ready), 0);
    check("rst_rsp_valid", 0, 32'(rsp_valid), 0);
    check("rst_rsp_data", 0, 32'(rsp_data), 0);
    check("rst_rsp_err", 0, 32'(rsp_err), 0);
    check("rst_depth", 0, 32'(depth), 0);
    check("rst_cmd", 0, 32'(stk_command), 0);
    check("rst_index", 0, 32'(stk_index), 0);
    check("rst_bus", 0, 32'(stk_data), 0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      do_req(tbl[i], 0, i);
    end

    // Pop with the consumer stalling for 4 cycles.
    do_req(mk(2, 0, 0, 0, 8, 4, 3), 4, 100);

    // Reset while the stack is driving read data.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd2;
    t = 0;
    while (req_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst_seq_accept", 200, 32'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_seq_sample_bus", 200, 32'(stk_data), 6);
    reset = 1'b1;
    @(negedge clk);
    check("rst_seq_depth", 200, 32'(depth), 0);
    check("rst_seq_cmd", 200, 32'(stk_command), 0);
    check("rst_seq_bus", 200, 32'(stk_data), 0);
    check("rst_seq_valid", 200, 32'(rsp_valid), 0);
    check("rst_seq_ready", 200, 32'(req_ready), 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_seq_no_rsp", 201 + k, 32'(rsp_valid), 0);
    end

    do_req(mk(1, 5, 0, 0, 0, 1, 2), 0, 300);
    do_req(mk(2, 0, 0, 0, 5, 0, 3), 0, 301);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 0, exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
